// File: rtl/pipeline_sink_buffer_if.sv
// Handshake bundle between the upstream pipeline, the sink buffer and the downstream consumer.
// The slave side is the buffer; the master side is the upstream/downstream environment.
interface pipeline_sink_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  issue;
    logic                  issue_en;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out;
    logic                  out_ready;
    logic                  err;

    modport master (
        output issue, in_valid, in, out_ready,
        input  issue_en, out_valid, out, err
    );

    modport slave (
        input  issue, in_valid, in, out_ready,
        output issue_en, out_valid, out, err
    );
endinterface

// File: rtl/pipeline_sink_buffer.sv
// Receive end of a non-stallable fixed-latency pipeline: credit-gated issue, FWFT circular FIFO,
// sticky protocol-error flag.
module pipeline_sink_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int PIPELINE_N = 2,
    parameter int DEPTH      = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    pipeline_sink_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(DEPTH);

    if (DEPTH < PIPELINE_N + 1) begin : g_depth_check
        $error("pipeline_sink_buffer: DEPTH must be at least PIPELINE_N+1");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic issue_ok, push, pop, overflow, underflow, bad_issue;

    // Credit check looks only at registered state so issue_en never depends on this cycle's inputs.
    assign bus.issue_en  = ({1'b0, count_q} + {1'b0, inflight_q}) < CREDIT_MAX;
    assign bus.out_valid = (count_q != '0);
    assign bus.out       = mem_q[rd_ptr_q];
    assign bus.err       = err_q;

    always_comb begin
        issue_ok  = bus.issue && bus.issue_en;
        bad_issue = bus.issue && !bus.issue_en;
        pop       = bus.out_valid && bus.out_ready;
        push      = bus.in_valid && ((count_q != CNT_FULL) || pop);
        overflow  = bus.in_valid && !push;
        underflow = bus.in_valid && !issue_ok && (inflight_q == '0);

        inflight_d = inflight_q;
        if (issue_ok && !bus.in_valid) begin
            inflight_d = inflight_q + CNT_ONE;
        end else if (!issue_ok && bus.in_valid && (inflight_q != '0)) begin
            inflight_d = inflight_q - CNT_ONE;
        end

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        end

        err_d = err_q | overflow | bad_issue | underflow;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Storage is deliberately left out of reset; out is only meaningful while out_valid is high.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_pipeline_sink_buffer.sv
// Directed bench for pipeline_sink_buffer (DATA_WIDTH=32, PIPELINE_N=2, DEPTH=4) with a
// two-stage upstream pipeline model that only carries words whose issue was accepted.
module tb_pipeline_sink_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_sink_buffer_if #(.DATA_WIDTH(32)) bus();

    pipeline_sink_buffer #(
        .DATA_WIDTH(32),
        .PIPELINE_N(2),
        .DEPTH(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic        pv0, pv1;
    logic [31:0] pd0, pd1;
    logic [31:0] recv[$];
    logic [31:0] next_word;
    int          cyc, en_low, first_valid, acc_cnt;

    task automatic clear_tb_state();
        pv0 = 1'b0; pv1 = 1'b0; pd0 = '0; pd1 = '0;
        recv.delete();
        cyc = 0; en_low = 0; first_valid = -1; acc_cnt = 0; next_word = 32'd1;
    endtask

    task automatic do_reset();
        bus.issue = 1'b0; bus.in_valid = 1'b0; bus.in = '0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        clear_tb_state();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: drive inputs, record observations, advance the upstream pipeline model.
    task automatic cycle(input logic iss_req, input logic honor, input logic inj, input logic [31:0] inj_d);
        logic acc;
        bus.issue = iss_req && (!honor || bus.issue_en);
        acc = bus.issue && bus.issue_en;
        if (inj) begin
            bus.in_valid = 1'b1; bus.in = inj_d;
        end else begin
            bus.in_valid = pv1; bus.in = pd1;
        end
        if (!bus.issue_en) en_low++;
        if (bus.out_valid && first_valid < 0) first_valid = cyc;
        if (bus.out_valid && bus.out_ready) recv.push_back(bus.out);
        @(posedge clk);
        pv1 = pv0; pd1 = pd0;
        pv0 = acc; pd0 = next_word;
        if (acc) begin
            acc_cnt++;
            next_word++;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        bus.issue = 1'b0; bus.in_valid = 1'b0; bus.in = '0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #3;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.issue_en !== 1'b1) begin n_fail++; $display("FAIL reset_issue_en: got %b expected 1", bus.issue_en); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        do_reset();
    endtask

    task automatic test_streaming();
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 13; k++) cycle(k < 8, 1'b1, 1'b0, '0);
        n_checks++; if (first_valid !== 3) begin n_fail++; $display("FAIL stream_first_valid_cycle: got %0d expected 3", first_valid); end
        n_checks++; if (en_low !== 0) begin n_fail++; $display("FAIL stream_issue_en_low_cycles: got %0d expected 0", en_low); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL stream_err: got %b expected 0", bus.err); end
        n_checks++; if (recv.size() !== 8) begin n_fail++; $display("FAIL stream_count: got %0d expected 8", recv.size()); end
        for (int i = 0; i < recv.size() && i < 8; i++) begin
            n_checks++;
            if (recv[i] !== 32'(i + 1)) begin n_fail++; $display("FAIL stream_word[%0d]: got %0h expected %0h", i, recv[i], i + 1); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b1, 1'b0, '0);
        n_checks++; if (acc_cnt !== 4) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 4", acc_cnt); end
        n_checks++; if (bus.issue_en !== 1'b0) begin n_fail++; $display("FAIL bp_issue_en_full: got %b expected 0", bus.issue_en); end
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b expected 1", bus.out_valid); end
        n_checks++; if (bus.out !== 32'd1) begin n_fail++; $display("FAIL bp_head: got %0h expected 1", bus.out); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL bp_err: got %b expected 0", bus.err); end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 1'b0, '0);
        n_checks++; if (recv.size() !== 4) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected 4", recv.size()); end
        for (int i = 0; i < recv.size() && i < 4; i++) begin
            n_checks++;
            if (recv[i] !== 32'(i + 1)) begin n_fail++; $display("FAIL bp_word[%0d]: got %0h expected %0h", i, recv[i], i + 1); end
        end
        n_checks++; if (bus.issue_en !== 1'b1) begin n_fail++; $display("FAIL bp_issue_en_after: got %b expected 1", bus.issue_en); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_w[5];
        exp_w = '{32'd1, 32'd2, 32'd3, 32'd4, 32'h55};
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, 1'b0, '0);
        n_checks++; if (bus.issue_en !== 1'b0) begin n_fail++; $display("FAIL full_issue_en: got %b expected 0", bus.issue_en); end
        bus.out_ready = 1'b1;
        cycle(1'b0, 1'b1, 1'b1, 32'h55);
        n_checks++; if (bus.issue_en !== 1'b0) begin n_fail++; $display("FAIL full_pp_still_full: got %b expected 0", bus.issue_en); end
        n_checks++; if (bus.out !== 32'd2) begin n_fail++; $display("FAIL full_pp_head: got %0h expected 2", bus.out); end
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 1'b0, '0);
        n_checks++; if (recv.size() !== 5) begin n_fail++; $display("FAIL full_pp_count: got %0d expected 5", recv.size()); end
        for (int i = 0; i < recv.size() && i < 5; i++) begin
            n_checks++;
            if (recv[i] !== exp_w[i]) begin n_fail++; $display("FAIL full_pp_word[%0d]: got %0h expected %0h", i, recv[i], exp_w[i]); end
        end
    endtask

    task automatic test_errors();
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, 1'b0, '0);
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_before_illegal: got %b expected 0", bus.err); end
        cycle(1'b1, 1'b0, 1'b0, '0);
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_illegal_issue: got %b expected 1", bus.err); end
        cycle(1'b0, 1'b1, 1'b1, 32'hEE);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 1'b0, '0);
        n_checks++; if (recv.size() !== 4) begin n_fail++; $display("FAIL err_overflow_dropped: got %0d words expected 4", recv.size()); end
        for (int i = 0; i < recv.size() && i < 4; i++) begin
            n_checks++;
            if (recv[i] !== 32'(i + 1)) begin n_fail++; $display("FAIL err_word[%0d]: got %0h expected %0h", i, recv[i], i + 1); end
        end
        bus.out_ready = 1'b0;
        acc_cnt = 0;
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b1, 1'b0, '0);
        n_checks++; if (acc_cnt !== 4) begin n_fail++; $display("FAIL err_inflight_unchanged: got %0d accepted expected 4", acc_cnt); end
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", bus.err); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_cleared_by_reset: got %b expected 0", bus.err); end
        do_reset();
        cycle(1'b0, 1'b1, 1'b1, 32'h77);
        n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_underflow: got %b expected 1", bus.err); end
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL underflow_pushed: got %b expected 1", bus.out_valid); end
        n_checks++; if (bus.out !== 32'h77) begin n_fail++; $display("FAIL underflow_word: got %0h expected 77", bus.out); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 1'b0, '0);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", bus.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.issue_en !== 1'b1) begin n_fail++; $display("FAIL mid_issue_en: got %b expected 1", bus.issue_en); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %b expected 0", bus.err); end
        bus.issue = 1'b0; bus.in_valid = 1'b0;
        clear_tb_state();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        next_word = 32'hA5;
        bus.out_ready = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, '0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, '0);
        n_checks++; if (first_valid !== 3) begin n_fail++; $display("FAIL mid_first_valid_cycle: got %0d expected 3", first_valid); end
        n_checks++; if (recv.size() !== 1) begin n_fail++; $display("FAIL mid_count: got %0d expected 1", recv.size()); end
        if (recv.size() > 0) begin
            n_checks++;
            if (recv[0] !== 32'hA5) begin n_fail++; $display("FAIL mid_word: got %0h expected a5", recv[0]); end
        end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL mid_err_after: got %b expected 0", bus.err); end
    endtask

    task automatic test_wrap();
        do_reset();
        next_word = 32'h10;
        for (int k = 0; k < 80 && recv.size() < 10; k++) begin
            bus.out_ready = k[0];
            cycle(acc_cnt < 10, 1'b1, 1'b0, '0);
        end
        n_checks++; if (recv.size() !== 10) begin n_fail++; $display("FAIL wrap_count: got %0d expected 10", recv.size()); end
        for (int i = 0; i < recv.size() && i < 10; i++) begin
            n_checks++;
            if (recv[i] !== 32'(32'h10 + i)) begin n_fail++; $display("FAIL wrap_word[%0d]: got %0h expected %0h", i, recv[i], 32'h10 + i); end
        end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %b expected 0", bus.err); end
    endtask

    initial begin
        clear_tb_state();
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_push_pop();
        test_errors();
        test_reset_midstream();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
